// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, state encodings and widths for the pipeline run/debug controller.
// Used by pipeline_run_ctrl and ctrl_down_counter.
package pipe_ctrl_pkg;

    localparam int PC_W  = 11;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_ONE = 16'd1;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_LOAD_I   = 3'd1;
    localparam logic [2:0] OP_LOAD_D   = 3'd2;
    localparam logic [2:0] OP_RUN      = 3'd3;
    localparam logic [2:0] OP_HALT     = 3'd4;
    localparam logic [2:0] OP_STEP     = 3'd5;
    localparam logic [2:0] OP_CORE_RST = 3'd6;
    localparam logic [2:0] OP_SET_BP   = 3'd7;

    typedef enum logic [2:0] {
        ST_HALT  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_RESET = 3'd4
    } ctrl_state_e;

    // A zero step count still advances the pipeline by one cycle.
    function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] raw);
        return (raw == '0) ? CNT_ONE : raw;
    endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable 16-bit down counter with zero flag; times both single/multi-step runs
// and the core reset pulse. Saturates at zero.
module ctrl_down_counter
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Host run/debug controller for the 5-stage pipeline: LOAD, RUN, HALT, STEP, CORE_RST.
// Define PIPE_BREAKPOINT_EN to add a single PC breakpoint and the bp_hit output.
//
// state    | meaning
// HALT     | pipeline frozen, loader owns memories, commands accepted
// WRITE    | one-cycle loader write strobe to Icache or Dmem
// RUN      | pipeline free-running until HALT (or breakpoint)
// STEP     | pipeline enabled for a counted number of cycles
// RESET    | core_rst held for RST_CYCLES cycles
module pipeline_run_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int IMEM_AW    = 9,
    parameter int DMEM_AW    = 8,
    parameter int DW         = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [PC_W-1:0]    cmd_addr,
    input  logic [DW-1:0]      cmd_data,
    input  logic [PC_W-1:0]    pc_if,
    output logic               pipe_en,
    output logic               core_rst,
    output logic               mem_sel,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DW-1:0]      mem_din,
    output logic [2:0]         state_out,
`ifdef PIPE_BREAKPOINT_EN
    output logic               bp_hit,
`endif
    output logic [31:0]        cycle_cnt,
    output logic               err
);

    ctrl_state_e        state_q;
    logic               cmd_ready_q;
    logic               pipe_en_q;
    logic               core_rst_q;
    logic               mem_sel_q;
    logic               imem_we_q;
    logic               dmem_we_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [DMEM_AW-1:0] dmem_addr_q;
    logic [DW-1:0]      mem_din_q;
    logic [31:0]        cycle_cnt_q;
    logic               err_q;

    logic               cmd_acc;
    logic               bp_match;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_count;
    logic               cnt_zero;
    logic               cnt_last;

    assign cmd_acc  = cmd_valid && cmd_ready_q;
    assign cnt_last = (cnt_count == CNT_ONE);

`ifdef PIPE_BREAKPOINT_EN
    logic [PC_W-1:0] bp_addr_q;
    logic            bp_valid_q;
    logic            bp_hit_q;
    logic            unused_addr_bits;

    // Only a live fetch from the breakpoint address stops the core.
    assign bp_match = pipe_en_q && bp_valid_q && (pc_if == bp_addr_q)
                      && ((state_q == ST_RUN) || (state_q == ST_STEP));
    assign bp_hit   = bp_hit_q;
    assign unused_addr_bits = ^cmd_addr[1:0];
`else
    logic unused_addr_bits;

    assign bp_match = 1'b0;
    assign unused_addr_bits = ^{cmd_addr[1:0], pc_if};
`endif

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (cmd_acc && (cmd_op == OP_STEP)) begin
                    cnt_load = 1'b1;
                    cnt_val  = step_count(cmd_data[CNT_W-1:0]);
                end else if (cmd_acc && (cmd_op == OP_CORE_RST)) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(RST_CYCLES);
                end
            end
            ST_STEP: begin
                if (bp_match) begin
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESET: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    ctrl_down_counter u_step_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_count),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HALT;
            cmd_ready_q <= 1'b1;
            pipe_en_q   <= 1'b0;
            core_rst_q  <= 1'b0;
            mem_sel_q   <= 1'b1;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            mem_din_q   <= '0;
            cycle_cnt_q <= '0;
            err_q       <= 1'b0;
`ifdef PIPE_BREAKPOINT_EN
            bp_addr_q   <= '0;
            bp_valid_q  <= 1'b0;
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
`ifdef PIPE_BREAKPOINT_EN
            bp_hit_q  <= 1'b0;
`endif
            if (pipe_en_q) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end

            case (state_q)
                ST_HALT: begin
                    if (cmd_acc) begin
                        case (cmd_op)
                            OP_LOAD_I: begin
                                state_q     <= ST_WRITE;
                                cmd_ready_q <= 1'b0;
                                imem_we_q   <= 1'b1;
                                imem_addr_q <= cmd_addr[IMEM_AW+1:2];
                                mem_din_q   <= cmd_data;
                            end
                            OP_LOAD_D: begin
                                state_q     <= ST_WRITE;
                                cmd_ready_q <= 1'b0;
                                dmem_we_q   <= 1'b1;
                                dmem_addr_q <= cmd_addr[DMEM_AW+1:2];
                                mem_din_q   <= cmd_data;
                            end
                            OP_RUN: begin
                                state_q   <= ST_RUN;
                                pipe_en_q <= 1'b1;
                                mem_sel_q <= 1'b0;
                            end
                            OP_STEP: begin
                                state_q     <= ST_STEP;
                                cmd_ready_q <= 1'b0;
                                pipe_en_q   <= 1'b1;
                                mem_sel_q   <= 1'b0;
                            end
                            OP_CORE_RST: begin
                                state_q     <= ST_RESET;
                                cmd_ready_q <= 1'b0;
                                core_rst_q  <= 1'b1;
                                cycle_cnt_q <= '0;
                            end
                            OP_SET_BP: begin
`ifdef PIPE_BREAKPOINT_EN
                                bp_addr_q  <= cmd_addr;
                                bp_valid_q <= cmd_data[0];
`else
                                err_q <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end

                ST_WRITE: begin
                    state_q     <= ST_HALT;
                    cmd_ready_q <= 1'b1;
                end

                ST_RUN: begin
                    // Commands are still accepted here; anything but HALT/NOP is dropped.
                    if (cmd_acc && (cmd_op != OP_NOP) && (cmd_op != OP_HALT)) begin
                        err_q <= 1'b1;
                    end
                    if (bp_match || (cmd_acc && (cmd_op == OP_HALT))) begin
                        state_q   <= ST_HALT;
                        pipe_en_q <= 1'b0;
                        mem_sel_q <= 1'b1;
                    end
`ifdef PIPE_BREAKPOINT_EN
                    if (bp_match) begin
                        bp_hit_q <= 1'b1;
                    end
`endif
                end

                ST_STEP: begin
                    if (bp_match || cnt_last || cnt_zero) begin
                        state_q     <= ST_HALT;
                        cmd_ready_q <= 1'b1;
                        pipe_en_q   <= 1'b0;
                        mem_sel_q   <= 1'b1;
                    end
`ifdef PIPE_BREAKPOINT_EN
                    if (bp_match) begin
                        bp_hit_q <= 1'b1;
                    end
`endif
                end

                ST_RESET: begin
                    if (cnt_last || cnt_zero) begin
                        state_q     <= ST_HALT;
                        cmd_ready_q <= 1'b1;
                        core_rst_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_HALT;
                    cmd_ready_q <= 1'b1;
                    pipe_en_q   <= 1'b0;
                    core_rst_q  <= 1'b0;
                    mem_sel_q   <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign pipe_en   = pipe_en_q;
    assign core_rst  = core_rst_q;
    assign mem_sel   = mem_sel_q;
    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign dmem_we   = dmem_we_q;
    assign dmem_addr = dmem_addr_q;
    assign mem_din   = mem_din_q;
    assign state_out = state_q;
    assign cycle_cnt = cycle_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: a vector table for per-cycle behaviour
// plus directed sequences for multi-cycle timing; breakpoint section under PIPE_BREAKPOINT_EN.
module tb_pipeline_run_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [10:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [10:0] pc_if;
    logic        pipe_en;
    logic        core_rst;
    logic        mem_sel;
    logic        imem_we;
    logic [8:0]  imem_addr;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] mem_din;
    logic [2:0]  state_out;
    logic [31:0] cycle_cnt;
    logic        err;
`ifdef PIPE_BREAKPOINT_EN
    logic        bp_hit;
`endif

    pipeline_run_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .pc_if     (pc_if),
        .pipe_en   (pipe_en),
        .core_rst  (core_rst),
        .mem_sel   (mem_sel),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .mem_din   (mem_din),
        .state_out (state_out),
`ifdef PIPE_BREAKPOINT_EN
        .bp_hit    (bp_hit),
`endif
        .cycle_cnt (cycle_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [10:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    task automatic send(input logic [2:0] op, input logic [10:0] a, input logic [31:0] d);
        drive(op, a, d);
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // {state, pipe_en, mem_sel, cmd_ready, imem_we, dmem_we, core_rst, err}
    function automatic logic [9:0] ex(input logic [2:0] st, input logic pe, input logic ms,
                                      input logic rdy, input logic iwe, input logic dwe,
                                      input logic crst, input logic er);
        return {st, pe, ms, rdy, iwe, dwe, crst, er};
    endfunction

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [10:0] addr;
        logic [31:0] data;
        logic [9:0]  exp;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int pe_cnt, bad_cnt, we_cnt, rst_cnt;

    initial begin
        idle();
        pc_if = '0;

        vecs[0]  = '{1'b0, OP_NOP,      11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, OP_NOP,      11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[2]  = '{1'b1, OP_LOAD_I,   11'h008, 32'hDEADBEEF, ex(3'd1, 0, 1, 0, 1, 0, 0, 0)};
        vecs[3]  = '{1'b1, OP_RUN,      11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[4]  = '{1'b1, OP_LOAD_D,   11'h01C, 32'h12345678, ex(3'd1, 0, 1, 0, 0, 1, 0, 0)};
        vecs[5]  = '{1'b0, OP_NOP,      11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[6]  = '{1'b1, OP_RUN,      11'h000, 32'h0,        ex(3'd2, 1, 0, 1, 0, 0, 0, 0)};
        vecs[7]  = '{1'b1, OP_NOP,      11'h000, 32'h0,        ex(3'd2, 1, 0, 1, 0, 0, 0, 0)};
        vecs[8]  = '{1'b1, OP_LOAD_D,   11'h020, 32'h55,       ex(3'd2, 1, 0, 1, 0, 0, 0, 1)};
        vecs[9]  = '{1'b1, OP_HALT,     11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 1)};
        vecs[10] = '{1'b1, OP_HALT,     11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 1)};
        vecs[11] = '{1'b1, OP_STEP,     11'h000, 32'h2,        ex(3'd3, 1, 0, 0, 0, 0, 0, 1)};
        vecs[12] = '{1'b0, OP_NOP,      11'h000, 32'h0,        ex(3'd3, 1, 0, 0, 0, 0, 0, 1)};
        vecs[13] = '{1'b0, OP_NOP,      11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 1)};
        vecs[14] = '{1'b1, OP_CORE_RST, 11'h000, 32'h0,        ex(3'd4, 0, 1, 0, 0, 0, 1, 1)};
        vecs[15] = '{1'b0, OP_NOP,      11'h000, 32'h0,        ex(3'd4, 0, 1, 0, 0, 0, 1, 1)};
        vecs[16] = '{1'b0, OP_NOP,      11'h000, 32'h0,        ex(3'd0, 0, 1, 1, 0, 0, 0, 1)};

        // Reset values
        do_reset();
        check("rst_state",     32'(state_out), 32'(ST_HALT));
        check("rst_pipe_en",   32'(pipe_en),   32'd0);
        check("rst_core_rst",  32'(core_rst),  32'd0);
        check("rst_mem_sel",   32'(mem_sel),   32'd1);
        check("rst_imem_we",   32'(imem_we),   32'd0);
        check("rst_dmem_we",   32'(dmem_we),   32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_mem_din",   mem_din,        32'd0);
        check("rst_cycle_cnt", cycle_cnt,      32'd0);
        check("rst_err",       32'(err),       32'd0);

        for (int i = 0; i < NVEC; i++) begin
            cmd_valid = vecs[i].vld;
            cmd_op    = vecs[i].op;
            cmd_addr  = vecs[i].addr;
            cmd_data  = vecs[i].data;
            tick();
            check($sformatf("vec%0d", i),
                  32'({state_out, pipe_en, mem_sel, cmd_ready, imem_we, dmem_we, core_rst, err}),
                  32'(vecs[i].exp));
        end
        idle();
        check("tbl_cycle_cnt_after_core_rst", cycle_cnt, 32'd0);

        // LOAD_I / LOAD_D write timing and addressing
        do_reset();
        drive(OP_LOAD_I, 11'h008, 32'hDEADBEEF);
        check("load_i_no_early_we", 32'(imem_we), 32'd0);
        tick();
        idle();
        check("load_i_we",        32'(imem_we),   32'd1);
        check("load_i_addr",      32'(imem_addr), 32'd2);
        check("load_i_din",       mem_din,        32'hDEADBEEF);
        check("load_i_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        check("load_i_we_single", 32'(imem_we),   32'd0);
        check("load_i_back_halt", 32'(state_out), 32'(ST_HALT));
        send(OP_LOAD_D, 11'h01C, 32'hCAFE0001);
        check("load_d_addr", 32'(dmem_addr), 32'd7);
        check("load_d_din",  mem_din,        32'hCAFE0001);
        check("load_d_no_imem_we", 32'(imem_we), 32'd0);
        tick();

        // RUN for 10 cycles then HALT
        send(OP_RUN, 11'h0, 32'h0);
        pe_cnt  = 0;
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (pipe_en) pe_cnt++;
            if (pipe_en && mem_sel) bad_cnt++;
            if (i == 9) drive(OP_HALT, 11'h0, 32'h0);
            tick();
            idle();
        end
        check("run_pipe_en_cycles", 32'(pe_cnt),    32'd10);
        check("run_mem_sel_low",    32'(bad_cnt),   32'd0);
        check("run_cycle_cnt",      cycle_cnt,      32'd10);
        check("run_back_halt",      32'(state_out), 32'(ST_HALT));

        // STEP 3 and STEP 0
        send(OP_STEP, 11'h0, 32'd3);
        pe_cnt  = 0;
        bad_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (pipe_en) pe_cnt++;
            if (pipe_en && cmd_ready) bad_cnt++;
            tick();
        end
        check("step3_cycles",     32'(pe_cnt),  32'd3);
        check("step3_ready_low",  32'(bad_cnt), 32'd0);
        check("step3_cycle_cnt",  cycle_cnt,    32'd13);
        send(OP_STEP, 11'h0, 32'h0);
        pe_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (pipe_en) pe_cnt++;
            tick();
        end
        check("step0_cycles",    32'(pe_cnt), 32'd1);
        check("step0_cycle_cnt", cycle_cnt,   32'd14);

        // Illegal command in RUN, then CORE_RST
        check("err_clear_before", 32'(err), 32'd0);
        send(OP_RUN, 11'h0, 32'h0);
        we_cnt = 0;
        drive(OP_LOAD_D, 11'h040, 32'h77);
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
            if (dmem_we) we_cnt++;
        end
        check("run_load_d_err",   32'(err),       32'd1);
        check("run_load_d_no_we", 32'(we_cnt),    32'd0);
        check("run_load_d_state", 32'(state_out), 32'(ST_RUN));
        send(OP_HALT, 11'h0, 32'h0);
        tick();
        check("pre_core_rst_cnt_nonzero", 32'(cycle_cnt != 32'd0), 32'd1);
        send(OP_CORE_RST, 11'h0, 32'h0);
        rst_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (core_rst) rst_cnt++;
            tick();
        end
        check("core_rst_cycles",   32'(rst_cnt),   32'd2);
        check("core_rst_cnt_zero", cycle_cnt,      32'd0);
        check("core_rst_halt",     32'(state_out), 32'(ST_HALT));

        // rst in the middle of a long STEP
        send(OP_STEP, 11'h0, 32'd100);
        tick();
        tick();
        check("step100_active", 32'(pipe_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state",    32'(state_out), 32'(ST_HALT));
        check("mid_rst_pipe_en",  32'(pipe_en),   32'd0);
        check("mid_rst_counter",  32'(dut.u_step_cnt.count_o), 32'd0);
        check("mid_rst_core_rst", 32'(core_rst),  32'd0);
        check("mid_rst_ready",    32'(cmd_ready), 32'd1);
        tick();
        check("mid_rst_stays_halt", 32'(pipe_en), 32'd0);

`ifdef PIPE_BREAKPOINT_EN
        begin
            int   hits;
            int   hit_i;
            logic pe_at_hit;
            logic prev_pe;
            do_reset();
            send(OP_SET_BP, 11'h010, 32'h1);
            check("bp_set_no_err", 32'(err), 32'd0);
            pc_if = '0;
            send(OP_RUN, 11'h0, 32'h0);
            hits      = 0;
            hit_i     = -1;
            pe_at_hit = 1'b1;
            prev_pe   = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (prev_pe) pc_if = pc_if + 11'd4;
                prev_pe = pipe_en;
                if (bp_hit) begin
                    hits++;
                    hit_i     = i;
                    pe_at_hit = pipe_en;
                end
                tick();
            end
            check("bp_hit_pulses",   32'(hits),      32'd1);
            check("bp_hit_cycle",    32'(hit_i),     32'd5);
            check("bp_pipe_en_off",  32'(pe_at_hit), 32'd0);
            check("bp_state_halt",   32'(state_out), 32'(ST_HALT));
            check("bp_pc_after",     32'(pc_if),     32'h014);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
Host-facing run/debug controller for the 5-stage pipeline datapath.
- Owns the pipeline-wide register enable and the core reset.
- Multiplexes the Icache and Dmem write ports between the host loader and the core.
- Sequences LOAD, RUN, HALT, single/multi-STEP and core-reset through a command handshake.

Parameters:
IMEM_AW, 9, Icache word-address width (512 words)
DMEM_AW, 8, Dmem word-address width
DW, 32, data width
RST_CYCLES, 2, cycles core_rst is held after a CORE_RST command (min 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset of this block
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller accepts command this cycle
cmd_op  in  3  0 NOP, 1 LOAD_I, 2 LOAD_D, 3 RUN, 4 HALT, 5 STEP, 6 CORE_RST, 7 SET_BP
cmd_addr  in  11  byte address for LOAD_I/LOAD_D/SET_BP
cmd_data  in  DW  write data; STEP count in [15:0]
pc_if  in  11  current byte PC from the pc register
pipe_en  out  1  enable for the pc and all pipeline registers
core_rst  out  1  reset to the pc and pipeline registers
mem_sel  out  1  1 = loader drives the Icache/Dmem ports, 0 = core drives them
imem_we  out  1  Icache write strobe
imem_addr  out  IMEM_AW  loader Icache word address (cmd_addr[10:2])
dmem_we  out  1  Dmem loader write strobe
dmem_addr  out  DMEM_AW  loader Dmem word address
mem_din  out  DW  loader write data
state_out  out  3  current FSM state encoding
cycle_cnt  out  32  count of cycles with pipe_en=1
err  out  1  sticky illegal-command flag

Behaviour:
- A command is accepted on the cycle where cmd_valid && cmd_ready.
- States: HALT, WRITE, RUN, STEP, RESET.
- Reset (rst=1) values:
  - state=HALT; pipe_en=0; core_rst=0; mem_sel=1; imem_we=0; dmem_we=0.
  - Address and data outputs = 0; cycle_cnt=0; err=0; step counter=0.
- Outputs:
  - All outputs are registered.
  - mem_sel=1 in HALT, WRITE and RESET; 0 in RUN and STEP.
- cmd_ready:
  - 1 in HALT and RUN.
  - 0 in WRITE, STEP and RESET.
- HALT:
  - LOAD_I / LOAD_D: latch address and data; go to WRITE. The next cycle has exactly one imem_we or dmem_we pulse, then return to HALT.
  - LOAD_I write latency is 1 cycle after accept.
  - RUN: go to RUN; pipe_en=1 from the next cycle.
  - STEP: load counter with cmd_data[15:0] (0 is treated as 1); go to STEP.
  - CORE_RST: go to RESET; core_rst=1 for exactly RST_CYCLES cycles; clear cycle_cnt; return to HALT.
  - HALT / NOP: no effect.
- RUN:
  - HALT: pipe_en=0 from the next cycle; go to HALT.
  - NOP: no effect.
  - Any other opcode is dropped and sets err.
- STEP:
  - pipe_en=1 for exactly N cycles; counter decrements each cycle.
  - At counter==1, return to HALT with pipe_en=0 the following cycle.
- cycle_cnt:
  - Increments on every cycle with pipe_en=1.
  - Wraps 0xFFFF_FFFF -> 0 with no flag.
- SET_BP without the optional feature: dropped, sets err.
- err is cleared only by rst.
- rst mid-operation (RUN, STEP, RESET or WRITE):
  - Immediate return to HALT.
  - Any pending write is discarded; core_rst is not asserted.

Optional Feature:
PIPE_BREAKPOINT_EN
- Enabled:
  - SET_BP (accepted in HALT) stores bp_addr=cmd_addr and sets bp_valid.
  - SET_BP with cmd_data[0]=0 clears bp_valid.
  - In RUN or STEP, if pipe_en=1 && bp_valid && pc_if==bp_addr: next state is HALT and pipe_en=0 from the next cycle. The PC is left at bp_addr+4.
  - bp_hit (extra 1-bit output) pulses for 1 cycle.
- Disabled:
  - No bp registers and no bp_hit port.
  - SET_BP is illegal.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams (OP_NOP..OP_SET_BP);
  - state encodings (ST_HALT=0, ST_WRITE=1, ST_RUN=2, ST_STEP=3, ST_RESET=4);
  - PC_W=11.
- One sub-module, ctrl_down_counter: 16-bit loadable down counter with zero flag, shared by STEP and RESET timing.

Test Plan:
1. rst then LOAD_I addr=0x008 data=0xDEADBEEF -> imem_we=1 exactly one cycle later, imem_addr=2, mem_din=0xDEADBEEF; cmd_ready=0 that cycle, back to HALT.
2. RUN, wait 10 cycles, HALT -> pipe_en high exactly 10 cycles; cycle_cnt=10; mem_sel=0 during RUN.
3. STEP data=3 -> pipe_en=1 for exactly 3 cycles, cmd_ready=0 throughout, cycle_cnt +3. STEP data=0 -> exactly 1 cycle.
4. In RUN issue LOAD_D -> err=1, no dmem_we, still RUN. CORE_RST from HALT -> core_rst high 2 cycles, cycle_cnt=0.
5. Assert rst during STEP with count=100 -> HALT next cycle, pipe_en=0, counter cleared.
6. (PIPE_BREAKPOINT_EN) SET_BP 0x010, RUN with pc_if sweeping 0,4,8,... -> bp_hit one cycle when pc_if=0x010; pipe_en=0 next cycle; state HALT.
